// File: rtl/calendar_set_ctrl.sv
// calendar_set_ctrl: button-driven year/month/day editor with shadow date, inactivity timeout and blink
module calendar_set_ctrl #(
    parameter int TIMEOUT_S = 30,
    parameter int YEAR_MIN  = 1900,
    parameter int YEAR_MAX  = 2099
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        tick_1Hz,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cancel,
    input  logic [4:0]  cur_day,
    input  logic [3:0]  cur_month,
    input  logic [11:0] cur_year,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [11:0] set_year,
    output logic        load,
    output logic        edit_active,
    output logic [1:0]  field_sel,
    output logic        blink
);
    typedef enum logic [1:0] {IDLE = 2'b00, YEAR = 2'b01, MONTH = 2'b10, DAY = 2'b11} state_t;
    localparam int CW = $clog2(TIMEOUT_S + 1);
    localparam logic [11:0] Y_MIN = 12'(YEAR_MIN);
    localparam logic [11:0] Y_MAX = 12'(YEAR_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_S - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [4:0] day_max;
    logic [4:0] day_clamp;
    logic any_btn;
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
        return (m == 4'd2) ? ((y[1:0] == 2'b00) ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction
    assign day_max     = days_in_month(set_month, set_year);
    assign day_clamp   = (set_day == 5'd0 || set_day > day_max) ? day_max : set_day;
    assign any_btn     = btn_mode | btn_up | btn_down | btn_cancel;
    assign field_sel   = state;
    assign edit_active = (state != IDLE);
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= IDLE;
            set_day   <= 5'd19;
            set_month <= 4'd7;
            set_year  <= 12'd1907;
            load      <= 1'b0;
            blink     <= 1'b0;
            cnt       <= '0;
        end else begin
            load <= 1'b0;
            if (state == IDLE) begin
                cnt   <= '0;
                blink <= 1'b0;
                if (btn_mode) begin
                    state     <= YEAR;
                    blink     <= 1'b1;
                    set_year  <= (cur_year < Y_MIN || cur_year > Y_MAX) ? Y_MIN : cur_year;
                    set_month <= (cur_month == 4'd0 || cur_month > 4'd12) ? 4'd1 : cur_month;
                    set_day   <= cur_day;
                end
            end else if (btn_cancel) begin
                state <= IDLE;
                blink <= 1'b0;
                cnt   <= '0;
            end else if (btn_mode) begin
                cnt   <= '0;
                blink <= 1'b1;
                if (state == YEAR) state <= MONTH;
                if (state == MONTH) begin
                    state   <= DAY;
                    set_day <= day_clamp;
                end
                if (state == DAY) begin
                    state <= IDLE;
                    load  <= 1'b1;
                    blink <= 1'b0;
                end
            end else if (any_btn) begin
                cnt   <= '0;
                blink <= 1'b1;
                if (btn_up ^ btn_down) begin
                    if (state == YEAR)
                        set_year <= btn_up ? ((set_year >= Y_MAX) ? Y_MIN : set_year + 12'd1)
                                           : ((set_year <= Y_MIN) ? Y_MAX : set_year - 12'd1);
                    if (state == MONTH)
                        set_month <= btn_up ? ((set_month >= 4'd12) ? 4'd1 : set_month + 4'd1)
                                            : ((set_month <= 4'd1) ? 4'd12 : set_month - 4'd1);
                    if (state == DAY)
                        set_day <= btn_up ? ((set_day >= day_max) ? 5'd1 : set_day + 5'd1)
                                          : ((set_day <= 5'd1) ? day_max : set_day - 5'd1);
                end
            end else if (tick_1Hz) begin
                if (cnt == CNT_LAST) begin
                    state <= IDLE;
                    blink <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt + CW'(1);
                    blink <= ~blink;
                end
            end
        end
    end
endmodule

// File: tb/tb_calendar_set_ctrl.sv
// tb_calendar_set_ctrl: table-driven vectors with a scoreboard queue for calendar_set_ctrl
module tb_calendar_set_ctrl;
    logic clk_100MHz = 1'b0;
    logic reset = 1'b0, tick_1Hz = 1'b0;
    logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
    logic [4:0] cur_day = '0;
    logic [3:0] cur_month = '0;
    logic [11:0] cur_year = '0;
    logic [4:0] set_day;
    logic [3:0] set_month;
    logic [11:0] set_year;
    logic load, edit_active, blink;
    logic [1:0] field_sel;
    always #5 clk_100MHz = ~clk_100MHz;
    calendar_set_ctrl dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load(load), .edit_active(edit_active), .field_sel(field_sel), .blink(blink)
    );
    typedef struct {
        logic [5:0]  b;
        logic [4:0]  cd;
        logic [3:0]  cm;
        logic [11:0] cy;
        logic [1:0]  fs;
        logic        ld;
        logic        bl;
        logic [4:0]  sd;
        logic [3:0]  sm;
        logic [11:0] sy;
    } vec_t;
    localparam logic [5:0] N = 6'b000000, T = 6'b000001, D = 6'b000010, U = 6'b000100;
    localparam logic [5:0] M = 6'b001000, C = 6'b010000, R = 6'b100000;
    vec_t q[$];
    vec_t tbl[$];
    int applied = 0;
    int miscompares = 0;
    function automatic vec_t v(input logic [5:0] b, input int cur, input int fs, input int ld,
                               input int bl, input int set);
        vec_t x;
        x.b  = b;
        x.cy = 12'(cur / 10000);
        x.cm = 4'((cur / 100) % 100);
        x.cd = 5'(cur % 100);
        x.fs = 2'(fs);
        x.ld = 1'(ld);
        x.bl = 1'(bl);
        x.sy = 12'(set / 10000);
        x.sm = 4'((set / 100) % 100);
        x.sd = 5'(set % 100);
        return x;
    endfunction
    task automatic apply(input vec_t x);
        @(negedge clk_100MHz);
        {reset, btn_cancel, btn_mode, btn_up, btn_down, tick_1Hz} = x.b;
        cur_day   = x.cd;
        cur_month = x.cm;
        cur_year  = x.cy;
        q.push_back(x);
    endtask
    always @(posedge clk_100MHz) begin : monitor
        vec_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            applied++;
            if ({field_sel, edit_active, load, blink, set_day, set_month, set_year} !==
                {e.fs, e.fs != 2'd0, e.ld, e.bl, e.sd, e.sm, e.sy}) begin
                miscompares++;
                $display("FAIL vec %0d: got fs=%0d ea=%0b ld=%0b bl=%0b set=%0d-%0d-%0d, want fs=%0d ea=%0b ld=%0b bl=%0b set=%0d-%0d-%0d",
                         applied, field_sel, edit_active, load, blink, set_year, set_month, set_day,
                         e.fs, e.fs != 2'd0, e.ld, e.bl, e.sy, e.sm, e.sd);
            end
        end
    end
    initial begin
        // leap-year-free month edit, then load and hold
        tbl.push_back(v(R,     20240210, 0, 0, 0, 19070719));
        tbl.push_back(v(N,     20240210, 0, 0, 0, 19070719));
        tbl.push_back(v(M,     20240210, 1, 0, 1, 20240210));
        tbl.push_back(v(M,     20240210, 2, 0, 1, 20240210));
        tbl.push_back(v(U,     20240210, 2, 0, 1, 20240310));
        tbl.push_back(v(M,     20240210, 3, 0, 1, 20240310));
        tbl.push_back(v(M,     20240210, 0, 1, 0, 20240310));
        tbl.push_back(v(N,     20240210, 0, 0, 0, 20240310));
        tbl.push_back(v(N,     20000101, 0, 0, 0, 20240310));
        // day clamp into February, non-leap then leap
        tbl.push_back(v(M,     20230131, 1, 0, 1, 20230131));
        tbl.push_back(v(M,     20230131, 2, 0, 1, 20230131));
        tbl.push_back(v(U,     20230131, 2, 0, 1, 20230231));
        tbl.push_back(v(M,     20230131, 3, 0, 1, 20230228));
        tbl.push_back(v(C,     20230131, 0, 0, 0, 20230228));
        tbl.push_back(v(M,     20240131, 1, 0, 1, 20240131));
        tbl.push_back(v(M,     20240131, 2, 0, 1, 20240131));
        tbl.push_back(v(U,     20240131, 2, 0, 1, 20240231));
        tbl.push_back(v(M,     20240131, 3, 0, 1, 20240229));
        tbl.push_back(v(D,     20240131, 3, 0, 1, 20240228));
        tbl.push_back(v(U,     20240131, 3, 0, 1, 20240229));
        tbl.push_back(v(U,     20240131, 3, 0, 1, 20240201));
        tbl.push_back(v(D,     20240131, 3, 0, 1, 20240229));
        tbl.push_back(v(C,     20240131, 0, 0, 0, 20240229));
        // year/month/day wraps, up+down together
        tbl.push_back(v(M,     20990401, 1, 0, 1, 20990401));
        tbl.push_back(v(U,     20990401, 1, 0, 1, 19000401));
        tbl.push_back(v(D,     20990401, 1, 0, 1, 20990401));
        tbl.push_back(v(U | D, 20990401, 1, 0, 1, 20990401));
        tbl.push_back(v(M,     20990401, 2, 0, 1, 20990401));
        tbl.push_back(v(D,     20990401, 2, 0, 1, 20990301));
        tbl.push_back(v(D,     20990401, 2, 0, 1, 20990201));
        tbl.push_back(v(D,     20990401, 2, 0, 1, 20990101));
        tbl.push_back(v(D,     20990401, 2, 0, 1, 20991201));
        tbl.push_back(v(U,     20990401, 2, 0, 1, 20990101));
        tbl.push_back(v(U,     20990401, 2, 0, 1, 20990201));
        tbl.push_back(v(U,     20990401, 2, 0, 1, 20990301));
        tbl.push_back(v(U,     20990401, 2, 0, 1, 20990401));
        tbl.push_back(v(M,     20990401, 3, 0, 1, 20990401));
        tbl.push_back(v(D,     20990401, 3, 0, 1, 20990430));
        tbl.push_back(v(U,     20990401, 3, 0, 1, 20990401));
        tbl.push_back(v(C | M, 20990401, 0, 0, 0, 20990401));
        // out-of-range capture, cancel+mode in MONTH, cancel in IDLE, day 0 clamp
        tbl.push_back(v(M,     18001300, 1, 0, 1, 19000100));
        tbl.push_back(v(M,     18001300, 2, 0, 1, 19000100));
        tbl.push_back(v(C | M, 18001300, 0, 0, 0, 19000100));
        tbl.push_back(v(C,     18001300, 0, 0, 0, 19000100));
        tbl.push_back(v(M,     18001300, 1, 0, 1, 19000100));
        tbl.push_back(v(M,     18001300, 2, 0, 1, 19000100));
        tbl.push_back(v(M,     18001300, 3, 0, 1, 19000131));
        tbl.push_back(v(M,     18001300, 0, 1, 0, 19000131));
        // reset while in DAY
        tbl.push_back(v(M,     18001300, 1, 0, 1, 19000100));
        tbl.push_back(v(M,     18001300, 2, 0, 1, 19000100));
        tbl.push_back(v(M,     18001300, 3, 0, 1, 19000131));
        tbl.push_back(v(R | M, 18001300, 0, 0, 0, 19070719));
        tbl.push_back(v(N,     18001300, 0, 0, 0, 19070719));
        tbl.push_back(v(T,     18001300, 0, 0, 0, 19070719));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        // full timeout: IDLE on the 30th tick, blink toggling, no load
        apply(v(M, 20240505, 1, 0, 1, 20240505));
        for (int k = 1; k <= 29; k++) apply(v(T, 20240505, 1, 0, 1 - k % 2, 20240505));
        apply(v(T, 20240505, 0, 0, 0, 20240505));
        // button coinciding with tick 29 restarts the count
        apply(v(M, 20240505, 1, 0, 1, 20240505));
        for (int k = 1; k <= 28; k++) apply(v(T, 20240505, 1, 0, 1 - k % 2, 20240505));
        apply(v(T | U, 20240505, 1, 0, 1, 20250505));
        for (int k = 1; k <= 29; k++) apply(v(T, 20240505, 1, 0, 1 - k % 2, 20250505));
        apply(v(T, 20240505, 0, 0, 0, 20250505));
        apply(v(N, 20240505, 0, 0, 0, 20250505));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_100MHz);
        {reset, btn_cancel, btn_mode, btn_up, btn_down, tick_1Hz} = N;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
